// File: rtl/pkt_cache_writer.sv
// Producer side of the 256-bit packet-cache write interface: turns an AXI-Stream
// slave into per-beat data writes plus one forward/discard flag write per packet.
module pkt_cache_writer #(
    parameter int    MAX_BEATS = 64,
    parameter string PLATFORM  = "xilinx"
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] s_axis_tdata,
    input  logic [31:0]  s_axis_tkeep,
    input  logic         s_axis_tuser,
    input  logic         s_axis_tlast,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic         out_cache_data_wr,
    output logic [255:0] out_cache_data,
    output logic [31:0]  out_cache_tkeep,
    output logic [1:0]   out_cache_tuser,
    output logic         out_cache_valid_wr,
    output logic         out_cache_valid,
    input  logic         in_cache_alf,
    output logic [31:0]  pkt_in_count,
    output logic [31:0]  pkt_drop_count,
    output logic [31:0]  pkt_trunc_count
);

    typedef enum logic [1:0] {IDLE_S, RECV_S, DROP_S} state_t;

    localparam logic [16:0] MAX_BEATS_W = 17'(MAX_BEATS);

    state_t         state_q, state_d;
    logic [15:0]    beat_cnt_q, beat_cnt_d;
    logic           err_q, err_d;
    logic           data_wr_q, data_wr_d;
    logic [255:0]   data_q, data_d;
    logic [31:0]    tkeep_q, tkeep_d;
    logic [1:0]     tuser_q, tuser_d;
    logic           valid_wr_q, valid_wr_d;
    logic           valid_q, valid_d;
    logic [31:0]    in_cnt_q, in_cnt_d;
    logic [31:0]    drop_cnt_q, drop_cnt_d;
    logic [31:0]    trunc_cnt_q, trunc_cnt_d;
    logic [16:0]    beat_next;
    logic           beat_acc;

    // Backpressure is only honoured at packet start; reset holds the slave off.
    assign s_axis_tready = rst_n && ((state_q == IDLE_S) ? !in_cache_alf : 1'b1);
    assign beat_acc      = s_axis_tvalid && s_axis_tready;
    assign beat_next     = {1'b0, beat_cnt_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        data_wr_d   = 1'b0;
        valid_wr_d  = 1'b0;
        valid_d     = 1'b0;
        data_d      = data_q;
        tkeep_d     = tkeep_q;
        tuser_d     = tuser_q;
        in_cnt_d    = in_cnt_q;
        trunc_cnt_d = trunc_cnt_q;

        if (beat_acc) begin
            case (state_q)
                IDLE_S: begin
                    data_wr_d  = 1'b1;
                    data_d     = s_axis_tdata;
                    tkeep_d    = s_axis_tkeep;
                    beat_cnt_d = 16'd1;
                    err_d      = s_axis_tuser;
                    in_cnt_d   = in_cnt_q + 32'd1;
                    if (s_axis_tlast) begin
                        tuser_d    = 2'b10;
                        valid_wr_d = 1'b1;
                        valid_d    = !s_axis_tuser;
                    end else if (MAX_BEATS_W == 17'd1) begin
                        tuser_d     = 2'b10;
                        valid_wr_d  = 1'b1;
                        trunc_cnt_d = trunc_cnt_q + 32'd1;
                        state_d     = DROP_S;
                    end else begin
                        tuser_d = 2'b01;
                        state_d = RECV_S;
                    end
                end
                RECV_S: begin
                    data_wr_d  = 1'b1;
                    data_d     = s_axis_tdata;
                    tkeep_d    = s_axis_tkeep;
                    beat_cnt_d = beat_next[15:0];
                    err_d      = err_q | s_axis_tuser;
                    if (s_axis_tlast) begin
                        tuser_d    = 2'b10;
                        valid_wr_d = 1'b1;
                        valid_d    = !(err_q | s_axis_tuser);
                        state_d    = IDLE_S;
                    end else if (beat_next == MAX_BEATS_W) begin
                        // Close the packet early as a discard; the rest is swallowed.
                        tuser_d     = 2'b10;
                        valid_wr_d  = 1'b1;
                        trunc_cnt_d = trunc_cnt_q + 32'd1;
                        state_d     = DROP_S;
                    end else begin
                        tuser_d = 2'b00;
                    end
                end
                DROP_S: begin
                    if (s_axis_tlast) begin
                        state_d = IDLE_S;
                    end
                end
                default: state_d = IDLE_S;
            endcase
        end

        drop_cnt_d = drop_cnt_q + {31'd0, valid_wr_d & !valid_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_S;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            data_wr_q   <= 1'b0;
            data_q      <= '0;
            tkeep_q     <= '0;
            tuser_q     <= '0;
            valid_wr_q  <= 1'b0;
            valid_q     <= 1'b0;
            in_cnt_q    <= '0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            data_wr_q   <= data_wr_d;
            data_q      <= data_d;
            tkeep_q     <= tkeep_d;
            tuser_q     <= tuser_d;
            valid_wr_q  <= valid_wr_d;
            valid_q     <= valid_d;
            in_cnt_q    <= in_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign out_cache_data_wr  = data_wr_q;
    assign out_cache_data     = data_q;
    assign out_cache_tkeep    = tkeep_q;
    assign out_cache_tuser    = tuser_q;
    assign out_cache_valid_wr = valid_wr_q;
    assign out_cache_valid    = valid_q;
    assign pkt_in_count       = in_cnt_q;
    assign pkt_drop_count     = drop_cnt_q;
    assign pkt_trunc_count    = trunc_cnt_q;

endmodule

// File: tb/tb_pkt_cache_writer.sv
// Scoreboard bench for pkt_cache_writer: a packet-level model predicts every cache
// write, and an independent monitor compares each write the DUT presents.
module tb_pkt_cache_writer;

    localparam int MAX_BEATS = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic         s_axis_tuser;
    logic         s_axis_tlast;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         out_cache_data_wr;
    logic [255:0] out_cache_data;
    logic [31:0]  out_cache_tkeep;
    logic [1:0]   out_cache_tuser;
    logic         out_cache_valid_wr;
    logic         out_cache_valid;
    logic         in_cache_alf;
    logic [31:0]  pkt_in_count;
    logic [31:0]  pkt_drop_count;
    logic [31:0]  pkt_trunc_count;

    pkt_cache_writer #(.MAX_BEATS(MAX_BEATS), .PLATFORM("xilinx")) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .out_cache_data_wr (out_cache_data_wr),
        .out_cache_data    (out_cache_data),
        .out_cache_tkeep   (out_cache_tkeep),
        .out_cache_tuser   (out_cache_tuser),
        .out_cache_valid_wr(out_cache_valid_wr),
        .out_cache_valid   (out_cache_valid),
        .in_cache_alf      (in_cache_alf),
        .pkt_in_count      (pkt_in_count),
        .pkt_drop_count    (pkt_drop_count),
        .pkt_trunc_count   (pkt_trunc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   tuser;
        logic         vw;
        logic         v;
        logic [31:0]  keep;
        logic [255:0] data;
    } beat_t;

    beat_t        sb_q[$];
    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    int           exp_in    = 0;
    int           exp_drop  = 0;
    int           exp_trunc = 0;
    logic [255:0] pkt_data[$];
    logic [31:0]  pkt_keep[$];
    logic         pkt_err[$];

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        chk_cnt++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic buildPacket(input int len, input int err_idx, input bit rand_err);
        pkt_data.delete();
        pkt_keep.delete();
        pkt_err.delete();
        for (int i = 0; i < len; i++) begin
            pkt_data.push_back(rand256());
            pkt_keep.push_back($urandom());
            pkt_err.push_back((i == err_idx) || (rand_err && ($urandom_range(0, 7) == 0)));
        end
    endtask

    // Packet-level reference: keep the first min(n, MAX) beats, last kept beat is the
    // tail, forward only if nothing was cut and no kept beat carried an error.
    task automatic modelPacket();
        int    n;
        int    w;
        bit    trunc;
        bit    bad;
        bit    fwd;
        beat_t b;
        n     = pkt_data.size();
        trunc = (n > MAX_BEATS);
        w     = trunc ? MAX_BEATS : n;
        bad   = 1'b0;
        for (int i = 0; i < w; i++) bad |= pkt_err[i];
        fwd = !trunc && !bad;
        for (int i = 0; i < w; i++) begin
            b.data  = pkt_data[i];
            b.keep  = pkt_keep[i];
            b.tuser = (i == w - 1) ? 2'b10 : ((i == 0) ? 2'b01 : 2'b00);
            b.vw    = (i == w - 1);
            b.v     = (i == w - 1) && fwd;
            sb_q.push_back(b);
        end
        exp_in++;
        if (trunc) exp_trunc++;
        if (!fwd) exp_drop++;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic driveBeat(input int i, input bit chk_ready);
        bit rdy;
        bit first;
        int budget;
        rdy    = 1'b0;
        first  = 1'b1;
        budget = 0;
        s_axis_tdata  = pkt_data[i];
        s_axis_tkeep  = pkt_keep[i];
        s_axis_tuser  = pkt_err[i];
        s_axis_tlast  = (i == pkt_data.size() - 1);
        s_axis_tvalid = 1'b1;
        while (!rdy) begin
            #1;
            rdy = s_axis_tready;
            if (first && chk_ready) checkValue("ready_expected", {63'd0, rdy}, 64'd1);
            first = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (!rdy) begin
                budget++;
                if (budget > 100) begin
                    failNow("accept_timeout");
                    break;
                end
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic applyStimulus(input bit gaps, input bit chk_mid);
        modelPacket();
        for (int i = 0; i < pkt_data.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_axis_tdata = rand256();
                    s_axis_tlast = $urandom_range(0, 1);
                    s_axis_tuser = $urandom_range(0, 1);
                    @(negedge clk);
                end
            end
            driveBeat(i, chk_mid && (i > 0));
        end
    endtask

    task automatic checkOutput();
        repeat (3) @(negedge clk);
        checkValue("pkt_in_count", {32'd0, pkt_in_count}, 64'(exp_in));
        checkValue("pkt_drop_count", {32'd0, pkt_drop_count}, 64'(exp_drop));
        checkValue("pkt_trunc_count", {32'd0, pkt_trunc_count}, 64'(exp_trunc));
        checkValue("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: every write the DUT presents is matched against the scoreboard head.
    initial begin : monitor
        beat_t e;
        beat_t a;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (out_cache_data_wr) begin
                    if (sb_q.size() == 0) begin
                        failNow("unexpected_data_wr");
                    end else begin
                        e       = sb_q.pop_front();
                        a.data  = out_cache_data;
                        a.keep  = out_cache_tkeep;
                        a.tuser = out_cache_tuser;
                        a.vw    = out_cache_valid_wr;
                        a.v     = e.vw ? out_cache_valid : 1'b0;
                        chk_cnt++;
                        if (a === e) pass_cnt++;
                        else $display("[TB] FAIL beat_write: got tuser=%b vw=%b v=%b keep=%h data=%h, expected tuser=%b vw=%b v=%b keep=%h data=%h",
                                      a.tuser, a.vw, a.v, a.keep, a.data, e.tuser, e.vw, e.v, e.keep, e.data);
                    end
                end else if (out_cache_valid_wr) begin
                    failNow("valid_wr_without_data_wr");
                end
            end
        end
    end

    initial begin
        int len;
        int wait_cnt;
        rst_n         = 1'b0;
        in_cache_alf  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkValue("reset_tready", {63'd0, s_axis_tready}, 64'd0);
        checkValue("reset_strobes", {59'd0, out_cache_data_wr, out_cache_valid_wr, out_cache_valid, out_cache_tuser}, 64'd0);
        checkValue("reset_counters", {32'd0, pkt_in_count | pkt_drop_count | pkt_trunc_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] 3-beat clean packet");
        buildPacket(3, -1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput();

        $display("[TB] single-beat errored packet");
        buildPacket(1, 0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput();

        $display("[TB] almost-full at packet start and mid-packet");
        buildPacket(3, -1, 1'b0);
        modelPacket();
        s_axis_tdata  = pkt_data[0];
        s_axis_tkeep  = pkt_keep[0];
        s_axis_tuser  = pkt_err[0];
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        in_cache_alf  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            checkValue("alf_blocks_tready", {63'd0, s_axis_tready}, 64'd0);
            checkValue("alf_no_write", {63'd0, out_cache_data_wr}, 64'd0);
            @(negedge clk);
        end
        in_cache_alf = 1'b0;
        driveBeat(0, 1'b1);
        in_cache_alf = 1'b1;
        driveBeat(1, 1'b1);
        driveBeat(2, 1'b1);
        in_cache_alf = 1'b0;
        checkOutput();

        $display("[TB] oversize packet truncation then normal packet");
        buildPacket(70, -1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        buildPacket(2, -1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        buildPacket(MAX_BEATS, -1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput();

        $display("[TB] middle-beat error with input gaps");
        buildPacket(5, 1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput();

        $display("[TB] randomized packets");
        for (int p = 0; p < 25; p++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 6);
            buildPacket(len, -1, 1'b1);
            applyStimulus($urandom_range(0, 1), 1'b1);
        end
        checkOutput();

        $display("[TB] reset in the middle of a packet");
        buildPacket(5, -1, 1'b0);
        modelPacket();
        driveBeat(0, 1'b0);
        driveBeat(1, 1'b0);
        s_axis_tdata  = pkt_data[2];
        s_axis_tkeep  = pkt_keep[2];
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        rst_n         = 1'b0;
        #1;
        checkValue("midreset_tready", {63'd0, s_axis_tready}, 64'd0);
        checkValue("midreset_outputs", {58'd0, out_cache_data_wr, out_cache_valid_wr, out_cache_valid, out_cache_tuser, |out_cache_data}, 64'd0);
        checkValue("midreset_counters", {32'd0, pkt_in_count | pkt_drop_count | pkt_trunc_count}, 64'd0);
        @(negedge clk);
        sb_q.delete();
        exp_in        = 0;
        exp_drop      = 0;
        exp_trunc     = 0;
        s_axis_tvalid = 1'b0;
        rst_n         = 1'b1;
        buildPacket(2, -1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput();

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (sb_q.size() != 0) failNow("final_drain");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
